// File: rtl/div_8bit_if.sv
// Start/done handshake bundle between the sequencer (master) and div_8bit (slave).
// With DIV_8BIT_UNSIGNED_OP_EN defined the bundle also carries the `us` mode bit.
interface div_8bit_if #(
    parameter int W = 8
);
    // Handshake: master raises start with x/y (and us) valid; the slave samples
    // them only when idle (busy=0). Results are valid while done is high and
    // remain stable afterwards until the next accepted start.
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
`ifdef DIV_8BIT_UNSIGNED_OP_EN
    logic         us;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         of;
    logic         dz;

`ifdef DIV_8BIT_UNSIGNED_OP_EN
    modport master (
        output start, x, y, us,
        input  busy, done, q, r, of, dz
    );

    modport slave (
        input  start, x, y, us,
        output busy, done, q, r, of, dz
    );
`else
    modport master (
        output start, x, y,
        input  busy, done, q, r, of, dz
    );

    modport slave (
        input  start, x, y,
        output busy, done, q, r, of, dz
    );
`endif
endinterface

// File: rtl/div_8bit.sv
// Sequential signed restoring divider: one subtract-and-compare per clock, W+1 cycles per op.
// Optional unsigned mode (bus.us) is built in when DIV_8BIT_UNSIGNED_OP_EN is defined.
module div_8bit #(
    parameter int W  = 8,
    parameter int CW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    div_8bit_if.slave  bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_dvd;
    logic [W-1:0]  r_dvs;
    logic [W-1:0]  r_rem;
    logic          r_x_neg;
    logic          r_q_neg;
    logic          r_of_pend;

    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_r;
    logic          r_of;
    logic          r_dz;

    logic          w_us;
    logic          w_x_neg;
    logic          w_y_neg;
    logic [W-1:0]  w_x_mag;
    logic [W-1:0]  w_y_mag;
    logic          w_of_case;
    logic [W+1:0]  w_shift;
    logic [W+1:0]  w_trial;
    logic          w_q_bit;
    logic [W-1:0]  w_rem_next;
    logic [W-1:0]  w_q_res;
    logic [W-1:0]  w_r_res;

`ifdef DIV_8BIT_UNSIGNED_OP_EN
    assign w_us = bus.us;
`else
    assign w_us = 1'b0;
`endif

    // Operand conditioning at acceptance; |-2^(W-1)| is representable as unsigned.
    always_comb begin
        w_x_neg   = bus.x[W-1] & ~w_us;
        w_y_neg   = bus.y[W-1] & ~w_us;
        w_x_mag   = w_x_neg ? (~bus.x + 1'b1) : bus.x;
        w_y_mag   = w_y_neg ? (~bus.y + 1'b1) : bus.y;
        w_of_case = ~w_us & (bus.x == {1'b1, {(W-1){1'b0}}}) & (bus.y == {W{1'b1}});
    end

    // Trial subtraction carries two spare bits so unsigned divisors up to 2^W-1
    // cannot overflow; the top bit is the borrow.
    always_comb begin
        w_shift    = {1'b0, r_rem, r_dvd[W-1]};
        w_trial    = w_shift - {2'b00, r_dvs};
        w_q_bit    = ~w_trial[W+1];
        w_rem_next = w_q_bit ? w_trial[W-1:0] : w_shift[W-1:0];
    end

    // Sign fix: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        w_q_res = r_q_neg ? (~r_dvd + 1'b1) : r_dvd;
        w_r_res = r_x_neg ? (~r_rem + 1'b1) : r_rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.y == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX:   w_next_state = S_IDLE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_x       <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_x_neg   <= 1'b0;
            r_q_neg   <= 1'b0;
            r_of_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
            r_of      <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x       <= bus.x;
                        r_x_neg   <= w_x_neg;
                        r_q_neg   <= w_x_neg ^ w_y_neg;
                        r_of_pend <= w_of_case;
                        r_dvd     <= w_x_mag;
                        r_dvs     <= w_y_mag;
                        r_rem     <= '0;
                        r_cnt     <= CW'(W - 1);
                        r_busy    <= 1'b1;
                        r_of      <= 1'b0;
                        r_dz      <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[W-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    // The -2^(W-1) / -1 case naturally yields q=2^(W-1), r=0.
                    r_q    <= w_q_res;
                    r_r    <= w_r_res;
                    r_of   <= r_of_pend;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_DONE: begin
                    r_q    <= '0;
                    r_r    <= r_x;
                    r_dz   <= 1'b1;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.q       = r_q;
    assign bus.r       = r_r;
    assign bus.of      = r_of;
    assign bus.dz      = r_dz;
    assign o_dbg_state = r_state;

endmodule
